// File: rtl/mcpu_control_fsm.sv
// mcpu_control_fsm: multi-cycle main controller for the MCPU datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// write enable and mux select. Stalls on mem_ready, halts on illegal opcodes
// or on a memory wait that exceeds WAIT_LIMIT cycles (0 = never time out).
module mcpu_control_fsm #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_we,
  output logic        reg_we,
  output logic        a_we,
  output logic        b_we,
  output logic        save_we,
  output logic        mem_in,
  output logic        dst,
  output logic        reg_in,
  output logic        jal,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic        timeout,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  MEMADDR = 4'd2,  MEMRD = 4'd3,
    MEMWB   = 4'd4,  MEMWR  = 4'd5,  RALU    = 4'd6,  IALU  = 4'd7,
    ALUWB   = 4'd8,  BRTGT  = 4'd9,  BRCMP   = 4'd10, JUMP  = 4'd11,
    JAL_S   = 4'd12, JR1    = 4'd13, JR2     = 4'd14, HALT  = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] A_PC   = 2'd0;
  localparam logic [1:0] A_REG  = 2'd1;
  localparam logic [1:0] B_IMM2 = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_REG  = 2'd2;
  localparam logic [1:0] B_FOUR = 2'd3;

  localparam logic [1:0] PC_JUMP  = 2'd1;
  localparam logic [1:0] PC_SAVED = 2'd2;
  localparam logic [1:0] PC_ALU   = 2'd3;

  // Counter is wide enough to hold WAIT_LIMIT; it saturates at all-ones.
  localparam int          CW       = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] LIMIT_C = CW'(WAIT_LIMIT);
  localparam bit          LIMIT_EN = (WAIT_LIMIT != 0);

  // R-type funct decode: returns {legal, alu_op}.
  function automatic logic [3:0] rtype_decode(input logic [5:0] f);
    logic [3:0] r;
    case (f)
      FN_ADD:  r = {1'b1, ALU_ADD};
      FN_SUB:  r = {1'b1, ALU_SUB};
      FN_XOR:  r = {1'b1, ALU_XOR};
      FN_SLT:  r = {1'b1, ALU_SLT};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  state_e          state_r, state_next_s;
  logic [CW-1:0]   wait_cnt_r, wait_cnt_next_s, cnt_inc_s;
  logic            timeout_r, timeout_next_s;
  logic [5:0]      opcode_s, funct_s;
  logic [3:0]      rdec_s;
  logic            wait_state_s, limit_hit_s;
  logic            pc_we_s, ir_we_s, mem_we_s, reg_we_s, a_we_s, b_we_s, save_we_s;
  logic            unused_instr_s;

  assign opcode_s       = instr[31:26];
  assign funct_s        = instr[5:0];
  assign rdec_s         = rtype_decode(funct_s);
  assign unused_instr_s = ^instr[25:6];

  assign wait_state_s = (state_r == FETCH) || (state_r == MEMRD) || (state_r == MEMWR);
  assign cnt_inc_s    = (wait_cnt_r == CNT_MAX) ? wait_cnt_r : (wait_cnt_r + {{(CW-1){1'b0}}, 1'b1});
  assign limit_hit_s  = LIMIT_EN && wait_state_s && !mem_ready && (cnt_inc_s >= LIMIT_C);

  // State, wait counter and timeout flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= FETCH;
      wait_cnt_r <= {CW{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      timeout_r  <= timeout_next_s;
    end
  end

  // Next-state selection, wait counting and timeout capture
  always_comb begin
    state_next_s    = state_r;
    timeout_next_s  = timeout_r;
    if (wait_state_s && !mem_ready) begin
      wait_cnt_next_s = cnt_inc_s;
    end else begin
      wait_cnt_next_s = {CW{1'b0}};
    end
    case (state_r)
      FETCH, MEMRD, MEMWR: begin
        if (limit_hit_s) begin
          state_next_s   = HALT;
          timeout_next_s = 1'b1;
        end else if (mem_ready) begin
          if (state_r == FETCH) begin
            state_next_s = DECODE;
          end else if (state_r == MEMRD) begin
            state_next_s = MEMWB;
          end else begin
            state_next_s = FETCH;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      DECODE: begin
        case (opcode_s)
          OP_LW, OP_SW:     state_next_s = MEMADDR;
          OP_RTYPE: begin
            if (funct_s == FN_JR) begin
              state_next_s = JR1;
            end else begin
              state_next_s = RALU;
            end
          end
          OP_ADDI, OP_XORI: state_next_s = IALU;
          OP_BEQ, OP_BNE:   state_next_s = BRTGT;
          OP_J:             state_next_s = JUMP;
          OP_JAL:           state_next_s = JAL_S;
          default:          state_next_s = HALT;
        endcase
      end
      MEMADDR: begin
        if (opcode_s == OP_LW) begin
          state_next_s = MEMRD;
        end else begin
          state_next_s = MEMWR;
        end
      end
      RALU: begin
        if (rdec_s[3]) begin
          state_next_s = ALUWB;
        end else begin
          state_next_s = HALT;
        end
      end
      IALU:    state_next_s = ALUWB;
      BRTGT:   state_next_s = BRCMP;
      JR1:     state_next_s = JR2;
      MEMWB, ALUWB, BRCMP, JUMP, JAL_S, JR2: state_next_s = FETCH;
      HALT:    state_next_s = HALT;
      default: state_next_s = HALT;
    endcase
  end

  // Moore output decode, qualified by mem_ready, alu_zero and instr where needed
  always_comb begin
    pc_we_s   = 1'b0;
    ir_we_s   = 1'b0;
    mem_we_s  = 1'b0;
    reg_we_s  = 1'b0;
    a_we_s    = 1'b0;
    b_we_s    = 1'b0;
    save_we_s = 1'b0;
    mem_in    = 1'b0;
    dst       = 1'b0;
    reg_in    = 1'b0;
    jal       = 1'b0;
    alu_src_a = A_PC;
    alu_src_b = B_IMM2;
    pc_src    = 2'd0;
    alu_op    = ALU_ADD;
    case (state_r)
      FETCH: begin
        alu_src_b = B_FOUR;
        if (mem_ready) begin
          ir_we_s   = 1'b1;
          save_we_s = 1'b1;
        end else begin
          ir_we_s   = 1'b0;
          save_we_s = 1'b0;
        end
      end
      DECODE: begin
        alu_src_b = B_FOUR;
        pc_we_s   = 1'b1;
        pc_src    = PC_SAVED;
        a_we_s    = 1'b1;
        b_we_s    = 1'b1;
      end
      MEMADDR: begin
        alu_src_a = A_REG;
        alu_src_b = B_IMM;
      end
      MEMRD: begin
        alu_src_a = A_REG;
        alu_src_b = B_IMM;
        mem_in    = 1'b1;
      end
      MEMWR: begin
        alu_src_a = A_REG;
        alu_src_b = B_IMM;
        mem_in    = 1'b1;
        mem_we_s  = 1'b1;
      end
      MEMWB: begin
        reg_we_s = 1'b1;
        dst      = 1'b1;
      end
      RALU: begin
        alu_src_a = A_REG;
        alu_src_b = B_REG;
        alu_op    = rdec_s[2:0];
      end
      IALU: begin
        alu_src_a = A_REG;
        alu_src_b = B_IMM;
        if (opcode_s == OP_XORI) begin
          alu_op = ALU_XOR;
        end else begin
          alu_op = ALU_ADD;
        end
      end
      ALUWB: begin
        reg_we_s = 1'b1;
        reg_in   = 1'b1;
        dst      = (opcode_s != OP_RTYPE);
      end
      BRTGT: begin
        alu_src_b = B_IMM2;
      end
      BRCMP: begin
        alu_src_a = A_REG;
        alu_src_b = B_REG;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALU;
        if (opcode_s == OP_BEQ) begin
          pc_we_s = alu_zero;
        end else begin
          pc_we_s = !alu_zero;
        end
      end
      JUMP: begin
        pc_we_s = 1'b1;
        pc_src  = PC_JUMP;
      end
      JAL_S: begin
        reg_we_s = 1'b1;
        reg_in   = 1'b1;
        jal      = 1'b1;
        pc_we_s  = 1'b1;
        pc_src   = PC_JUMP;
      end
      JR1: begin
        alu_src_a = A_REG;
        alu_src_b = B_REG;
      end
      JR2: begin
        pc_we_s = 1'b1;
        pc_src  = PC_ALU;
      end
      default: begin
        pc_we_s = 1'b0;
      end
    endcase
  end

  // Write enables are forced off while reset is held, even in FETCH.
  assign pc_we   = pc_we_s   & reset;
  assign ir_we   = ir_we_s   & reset;
  assign mem_we  = mem_we_s  & reset;
  assign reg_we  = reg_we_s  & reset;
  assign a_we    = a_we_s    & reset;
  assign b_we    = b_we_s    & reset;
  assign save_we = save_we_s & reset;

  assign halted  = (state_r == HALT);
  assign timeout = timeout_r;
  assign state   = state_r;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Self-checking bench for mcpu_control_fsm: directed vector table followed by
// randomized instruction streams compared against an instruction-level model.
module tb_mcpu_control_fsm;

  localparam int LIM = 4;

  localparam logic [6:0] E_PC   = 7'b1000000;
  localparam logic [6:0] E_IR   = 7'b0100000;
  localparam logic [6:0] E_MEMW = 7'b0010000;
  localparam logic [6:0] E_REG  = 7'b0001000;
  localparam logic [6:0] E_A    = 7'b0000100;
  localparam logic [6:0] E_B    = 7'b0000010;
  localparam logic [6:0] E_SAVE = 7'b0000001;
  localparam logic [6:0] E_NONE = 7'b0000000;

  logic        clk, reset, alu_zero, mem_ready;
  logic [31:0] instr;
  logic        pc_we, ir_we, mem_we, reg_we, a_we, b_we, save_we;
  logic        mem_in, dst, reg_in, jal, halted, timeout;
  logic [1:0]  alu_src_a, alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [3:0]  state;

  int checks   = 0;
  int failures = 0;

  mcpu_control_fsm #(.WAIT_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we),
    .reg_we(reg_we), .a_we(a_we), .b_we(b_we), .save_we(save_we),
    .mem_in(mem_in), .dst(dst), .reg_in(reg_in), .jal(jal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_op(alu_op), .halted(halted), .timeout(timeout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack an expected output record.
  function automatic logic [25:0] ov(input logic [6:0] en, input logic mi, d, ri, j,
                                     input logic [1:0] a, b, p, input logic [2:0] op,
                                     input logic h, t, input logic [3:0] st);
    return {en, mi, d, ri, j, a, b, p, op, h, t, st};
  endfunction

  task automatic check(input string name, input logic [25:0] exp);
    logic [25:0] act;
    act = {pc_we, ir_we, mem_we, reg_we, a_we, b_we, save_we, mem_in, dst, reg_in, jal,
           alu_src_a, alu_src_b, pc_src, alu_op, halted, timeout, state};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        az;
    logic        mr;
    logic [25:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string n, input logic r, input logic [31:0] i,
                     input logic az, input logic mr, input logic [25:0] e);
    vec_t v;
    v.rst = r; v.ins = i; v.az = az; v.mr = mr; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Each instruction becomes a list of named steps (state codes from the
  // state table); the model walks the list and tracks memory-wait time.
  int q[$];

  function automatic bit legal_funct(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h26) || (f == 6'h2A);
  endfunction

  task automatic push_instr(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    q.push_back(0);
    q.push_back(1);
    if (op == 6'h23) begin q.push_back(2); q.push_back(3); q.push_back(4); end
    else if (op == 6'h2B) begin q.push_back(2); q.push_back(5); end
    else if (op == 6'h00 && fn == 6'h08) begin q.push_back(13); q.push_back(14); end
    else if (op == 6'h00 && legal_funct(fn)) begin q.push_back(6); q.push_back(8); end
    else if (op == 6'h00) begin q.push_back(6); q.push_back(15); end
    else if (op == 6'h08 || op == 6'h0E) begin q.push_back(7); q.push_back(8); end
    else if (op == 6'h04 || op == 6'h05) begin q.push_back(9); q.push_back(10); end
    else if (op == 6'h02) q.push_back(11);
    else if (op == 6'h03) q.push_back(12);
    else q.push_back(15);
  endtask

  function automatic logic [25:0] model_out(input int st, input logic [31:0] ins,
                                            input logic az, input logic mr, input logic tmo);
    logic [5:0] op, fn;
    logic [2:0] rop;
    op = ins[31:26];
    fn = ins[5:0];
    case (fn)
      6'h22:   rop = 3'd1;
      6'h26:   rop = 3'd2;
      6'h2A:   rop = 3'd3;
      default: rop = 3'd0;
    endcase
    case (st)
      0:  return ov(mr ? (E_IR | E_SAVE) : E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0);
      1:  return ov(E_PC | E_A | E_B, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd2, 3'd0, 1'b0, 1'b0, 4'd1);
      2:  return ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd2);
      3:  return ov(E_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd3);
      4:  return ov(E_REG, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd4);
      5:  return ov(E_MEMW, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd5);
      6:  return ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, rop, 1'b0, 1'b0, 4'd6);
      7:  return ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, (op == 6'h0E) ? 3'd2 : 3'd0, 1'b0, 1'b0, 4'd7);
      8:  return ov(E_REG, 1'b0, (op != 6'h00), 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd8);
      9:  return ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd9);
      10: return ov(((op == 6'h04) == az) ? E_PC : E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd3, 3'd1, 1'b0, 1'b0, 4'd10);
      11: return ov(E_PC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 4'd11);
      12: return ov(E_PC | E_REG, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 4'd12);
      13: return ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 4'd13);
      14: return ov(E_PC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 3'd0, 1'b0, 1'b0, 4'd14);
      default: return ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, tmo, 4'd15);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  fns [4];
    int k;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h2A; fns[3] = 6'h26;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0, 1:   r[31:26] = 6'h23;
      2, 3:   r[31:26] = 6'h2B;
      4, 5, 15: begin r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 3)]; end
      6:      begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
      7:      r[31:26] = 6'h00;
      8:      r[31:26] = 6'h08;
      9:      r[31:26] = 6'h0E;
      10:     r[31:26] = 6'h04;
      11:     r[31:26] = 6'h05;
      12:     r[31:26] = 6'h02;
      13:     r[31:26] = 6'h03;
      default: r[31:26] = 6'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    logic [25:0] rst_o, fet, dec, halt0, exp;
    logic [31:0] addi, lw, sw, beq, bne, jali, jr, bad, cur;
    int waits, halt_cycles;
    logic tmo;

    rst_o = ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0);
    fet   = ov(E_IR | E_SAVE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0);
    dec   = ov(E_PC | E_A | E_B, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd2, 3'd0, 1'b0, 1'b0, 4'd1);
    halt0 = ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 4'd15);
    addi = 32'h20010005; lw = 32'h8C220004; sw = 32'hAC220004;
    beq  = 32'h10220003; bne = 32'h14220003; jali = 32'h0C000010;
    jr   = 32'h03E00008; bad = 32'hFC000000;

    for (int i = 0; i < 3; i++) add("reset", 1'b0, addi, 1'b0, 1'b1, rst_o);
    add("addi_fetch", 1'b1, addi, 1'b0, 1'b1, fet);
    add("addi_dec", 1'b1, addi, 1'b0, 1'b1, dec);
    add("addi_ialu", 1'b1, addi, 1'b0, 1'b1, ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd7));
    add("addi_wb", 1'b1, addi, 1'b0, 1'b1, ov(E_REG, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd8));
    add("lw_fetch", 1'b1, lw, 1'b0, 1'b1, fet);
    add("lw_dec", 1'b1, lw, 1'b0, 1'b1, dec);
    add("lw_addr", 1'b1, lw, 1'b0, 1'b0, ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd2));
    for (int i = 0; i < 3; i++)
      add("lw_stall", 1'b1, lw, 1'b0, 1'b0, ov(E_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd3));
    add("lw_rd", 1'b1, lw, 1'b0, 1'b1, ov(E_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd3));
    add("lw_wb", 1'b1, lw, 1'b0, 1'b1, ov(E_REG, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd4));
    add("beq_fetch", 1'b1, beq, 1'b1, 1'b1, fet);
    add("beq_dec", 1'b1, beq, 1'b1, 1'b1, dec);
    add("beq_tgt", 1'b1, beq, 1'b1, 1'b1, ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd9));
    add("beq_cmp", 1'b1, beq, 1'b1, 1'b1, ov(E_PC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd3, 3'd1, 1'b0, 1'b0, 4'd10));
    add("bne_fetch", 1'b1, bne, 1'b1, 1'b1, fet);
    add("bne_dec", 1'b1, bne, 1'b1, 1'b1, dec);
    add("bne_tgt", 1'b1, bne, 1'b1, 1'b1, ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd9));
    add("bne_cmp", 1'b1, bne, 1'b1, 1'b1, ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd3, 3'd1, 1'b0, 1'b0, 4'd10));
    add("jal_fetch", 1'b1, jali, 1'b0, 1'b1, fet);
    add("jal_dec", 1'b1, jali, 1'b0, 1'b1, dec);
    add("jal_exec", 1'b1, jali, 1'b0, 1'b1, ov(E_PC | E_REG, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 4'd12));
    add("jr_fetch", 1'b1, jr, 1'b0, 1'b1, fet);
    add("jr_dec", 1'b1, jr, 1'b0, 1'b1, dec);
    add("jr1", 1'b1, jr, 1'b0, 1'b1, ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0, 4'd13));
    add("jr2", 1'b1, jr, 1'b0, 1'b1, ov(E_PC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 3'd0, 1'b0, 1'b0, 4'd14));
    add("bad_fetch", 1'b1, bad, 1'b0, 1'b1, fet);
    add("bad_dec", 1'b1, bad, 1'b0, 1'b1, dec);
    add("bad_halt", 1'b1, bad, 1'b0, 1'b1, halt0);
    add("bad_halt_hold", 1'b1, bad, 1'b0, 1'b1, halt0);
    add("tmo_reset", 1'b0, addi, 1'b0, 1'b0, rst_o);
    for (int i = 0; i < LIM; i++) add("tmo_wait", 1'b1, addi, 1'b0, 1'b0, rst_o);
    add("tmo_halt", 1'b1, addi, 1'b0, 1'b0, ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b1, 4'd15));
    add("tmo_clear", 1'b0, addi, 1'b0, 1'b1, rst_o);
    add("sw_fetch", 1'b1, sw, 1'b0, 1'b1, fet);
    add("sw_dec", 1'b1, sw, 1'b0, 1'b1, dec);
    add("sw_addr", 1'b1, sw, 1'b0, 1'b1, ov(E_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd2));
    add("sw_wr", 1'b1, sw, 1'b0, 1'b0, ov(E_MEMW, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd5));
    add("sw_abort", 1'b0, sw, 1'b0, 1'b0, rst_o);
    add("post_abort_fetch", 1'b1, sw, 1'b0, 1'b1, fet);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; instr = tbl[i].ins; alu_zero = tbl[i].az; mem_ready = tbl[i].mr;
      @(negedge clk);
      check($sformatf("%s[%0d]", tbl[i].name, i), tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // Randomized instruction stream against the model.
    reset = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0;
    @(negedge clk);
    check("rand_reset", rst_o);
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete(); waits = 0; tmo = 1'b0; halt_cycles = 0; cur = 32'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (q.size() == 0) begin
        cur = rand_instr();
        push_instr(cur);
      end
      instr     = cur;
      alu_zero  = 1'($urandom);
      mem_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      exp = model_out(q[0], cur, alu_zero, mem_ready, tmo);
      check($sformatf("rand_cyc%0d_step%0d", cyc, q[0]), exp);
      if (q[0] == 15) begin
        halt_cycles++;
      end else if (q[0] == 0 || q[0] == 3 || q[0] == 5) begin
        if (mem_ready) begin
          waits = 0;
          void'(q.pop_front());
        end else begin
          waits++;
          if (waits >= LIM) begin
            q.delete(); q.push_back(15); tmo = 1'b1; waits = 0;
          end
        end
      end else begin
        void'(q.pop_front());
      end
      @(posedge clk);
      #1;
      if (halt_cycles >= 3 || $urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        @(negedge clk);
        check($sformatf("rand_reset_cyc%0d", cyc), rst_o);
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete(); waits = 0; tmo = 1'b0; halt_cycles = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcpu_control_fsm.md
Name: mcpu_control_fsm

Overview:
- Multi-cycle main controller for the MCPU datapath.
- Decodes the IR output and sequences fetch, decode, execute, memory and writeback, cycle by cycle.
- Drives every datapath write enable and mux select. Stalls on a memory ready handshake and halts on illegal opcodes or memory timeouts.
- Sits beside the datapath and replaces ad-hoc per-instruction enable logic.

Parameters:
WAIT_LIMIT, 16, max consecutive stall cycles in any memory-wait state before timeout halt; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr  in  32  IR contents; opcode [31:26], funct [5:0]
alu_zero  in  1  combinational ALU zero flag
mem_ready  in  1  memory has completed the current read/write this cycle
pc_we, ir_we, mem_we, reg_we, a_we, b_we, save_we  out  1 each  datapath write enables
mem_in  out  1  address select: 0 = PC, 1 = ALU reg
dst  out  1  write register select: 0 = rd, 1 = rt
reg_in  out  1  write data select: 0 = MDR, 1 = ALU reg
jal  out  1  force write register to r31
alu_src_a  out  2  0 = PC, 1 = A, 2 = BEN, 3 = zero
alu_src_b  out  2  0 = imm<<2, 1 = sign-extended imm, 2 = B, 3 = 4
pc_src  out  2  0 = branch mux, 1 = jump concat, 2 = saved PC+4, 3 = ALU reg
alu_op  out  3  ADD = 0, SUB = 1, XOR = 2, SLT = 3, AND = 4, NAND = 5, NOR = 6, OR = 7
halted  out  1  controller stopped
timeout  out  1  halt cause was a memory wait timeout
state  out  4  current state encoding, for debug

Behaviour:
- States:
  - FETCH = 0, DECODE = 1, MEMADDR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - RALU = 6, IALU = 7, ALUWB = 8, BRTGT = 9, BRCMP = 10.
  - JUMP = 11, JAL = 12, JR1 = 13, JR2 = 14, HALT = 15.
- Outputs are Moore decodes of state, plus mem_ready, alu_zero and instr where noted. Any output not listed for a state is 0.
- Reset low: state = FETCH, all enables = 0, halted = 0, timeout = 0, wait counter = 0.
  - Reset asserted mid-instruction aborts it immediately; no further writes occur.
  - First fetch happens in the first cycle after reset goes high.
- FETCH:
  - mem_in = 0; ALU computes PC+4 (alu_src_a = 0, alu_src_b = 3, ADD).
  - ir_we and save_we are asserted only in the cycle mem_ready = 1; that cycle transitions to DECODE. Otherwise FETCH holds.
- DECODE:
  - pc_we = 1 with pc_src = 2; a_we = b_we = 1.
  - ALU keeps PC+4, so the ALU reg holds the old PC+4 next cycle.
  - Next state by opcode:
    - 0x23 → MEMADDR, 0x2B → MEMADDR.
    - 0x00 with funct 0x08 → JR1; other 0x00 → RALU.
    - 0x08 or 0x0E → IALU.
    - 0x04 or 0x05 → BRTGT.
    - 0x02 → JUMP, 0x03 → JAL.
    - anything else → HALT.
- MEMADDR:
  - A + imm, ADD.
  - Next is MEMRD for LW, MEMWR for SW.
- MEMRD and MEMWR:
  - Hold the MEMADDR ALU selects so the ALU reg stays stable; mem_in = 1.
  - MEMWR asserts mem_we continuously until mem_ready.
  - On mem_ready: MEMRD → MEMWB, MEMWR → FETCH.
- MEMWB: reg_we = 1, reg_in = 0, dst = 1 → FETCH.
- RALU:
  - A op B. funct 0x20 ADD, 0x22 SUB, 0x2A SLT, 0x26 XOR.
  - Any other funct → HALT, with no writes in the RALU cycle.
  - → ALUWB.
- IALU: A op imm; ADDI uses ADD, XORI uses XOR → ALUWB.
- ALUWB: reg_we = 1, reg_in = 1; dst = 0 for R-type, 1 for I-type → FETCH.
- BRTGT: PC + (imm<<2), ADD → BRCMP.
- BRCMP:
  - A − B, SUB; pc_src = 3, so the ALU reg holds the target.
  - pc_we = alu_zero for BEQ, !alu_zero for BNE.
  - → FETCH.
- JUMP: pc_we = 1, pc_src = 1 → FETCH.
- JAL: reg_we = 1, reg_in = 1, jal = 1 (ALU reg = PC+4 from DECODE); pc_we = 1, pc_src = 1 → FETCH.
- JR1: A + B, ADD (rt = r0) → JR2.
- JR2: pc_we = 1, pc_src = 3 → FETCH.
- Wait counter:
  - Counts consecutive cycles with mem_ready = 0 in FETCH, MEMRD or MEMWR; cleared on mem_ready or on leaving those states.
  - If WAIT_LIMIT ≠ 0 and the counter reaches WAIT_LIMIT → HALT with timeout = 1.
  - The counter saturates; it never wraps.
- HALT: all enables 0, halted = 1. Exits only via reset.
- mem_ready is ignored outside the wait states.

Test Plan:
- Reset low for 3 cycles with mem_ready = 1 → all enables 0, state = 0. After release: ir_we = 1 in cycle 1, pc_we = 1 with pc_src = 2 in cycle 2.
- ADDI r1,r0,5 (0x20010005), mem_ready = 1 → states 0, 1, 7, 8. ALUWB shows reg_we = 1, reg_in = 1, dst = 1, alu_op = 0.
- LW with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles with selects constant, then MEMWB with reg_we = 1, reg_in = 0.
- BEQ with alu_zero = 1 → pc_we = 1, pc_src = 3 in BRCMP. BNE with alu_zero = 1 → pc_we = 0. Both return to FETCH.
- JAL 0x0C000010 → JAL state shows reg_we = jal = pc_we = 1, pc_src = 1. JR r31 → JR1 then JR2 with pc_src = 3.
- Opcode 0x3F → HALT, halted = 1, no enables. Separately, WAIT_LIMIT = 4 with mem_ready = 0 in FETCH → HALT after 4 cycles with timeout = 1; reset clears both.
